// File: rtl/rsa_decode_arbiter.sv
// Round-robin front end that shares one RSA decoder core between two requesters.
// One job in flight: accept -> SETUP -> RUN (core_start high) -> RESP -> IDLE.
module rsa_decode_arbiter #(
    parameter int n_bit   = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [n_bit-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [n_bit-1:0] req1_data,
    output logic             req1_ready,
    output logic             core_start,
    output logic [n_bit-1:0] core_data_in,
    input  logic             core_done,
    input  logic [n_bit-1:0] core_data_out,
    output logic             rsp_valid,
    output logic [n_bit-1:0] rsp_data,
    output logic             rsp_id,
    output logic             rsp_err,
    input  logic             rsp_ready,
    output logic [1:0]       dbg_state
);

    // Handshakes: a word moves on a rising edge where valid and ready are both
    // high; a producer holds valid and data stable until that edge, and ready
    // never depends on anything but state, pointer and the offered valids.

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic             ptr;
    logic [CNT_W-1:0] cnt;
    logic [n_bit-1:0] job_data;
    logic             job_id;
    logic [n_bit-1:0] res_data;
    logic             res_err;
    logic             grant0;
    logic             grant1;

    // Grant is combinational so an offer in IDLE is taken on the very next edge;
    // rst_n gating keeps both readies low while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && (state == S_IDLE)) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~ptr;
                grant1 = ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= 1'b0;
            cnt      <= '0;
            job_data <= '0;
            job_id   <= 1'b0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        job_data <= grant1 ? req1_data : req0_data;
                        job_id   <= grant1;
                        ptr      <= ~grant1;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    cnt   <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    // A done on the final allowed cycle still wins over the abort.
                    if (core_done) begin
                        res_data <= core_data_out;
                        res_err  <= 1'b0;
                        state    <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign core_start   = (state == S_RUN);
    assign core_data_in = job_data;
    assign rsp_valid    = (state == S_RESP);
    assign rsp_data     = res_data;
    assign rsp_id       = job_id;
    assign rsp_err      = res_err;
    assign dbg_state    = state;

endmodule

// File: doc/rsa_decode_arbiter.md
RSA_DECODE_ARBITER -- requirements
Module: rsa_decode_arbiter

Interface
REQ-001 The block SHALL have parameter n_bit, default 12, giving the width of every data word.
REQ-002 The block SHALL have parameter TIMEOUT, default 4095, giving the maximum number of core run cycles before abort.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have ports req0_valid, input, 1, and req0_data, input, n_bit: requester 0 ciphertext offer.
REQ-006 The block SHALL have port req0_ready, output, 1: requester 0 word accepted when high together with req0_valid.
REQ-007 The block SHALL have ports req1_valid, req1_data and req1_ready, with the same widths and meaning for requester 1.
REQ-008 The block SHALL have ports core_start, output, 1, and core_data_in, output, n_bit, which drive the shared decoder core.
REQ-009 The block SHALL have ports core_done, input, 1, and core_data_out, input, n_bit, returned by the core.
REQ-010 The block SHALL have port rsp_valid, output, 1, and rsp_data, output, n_bit: the plaintext result.
REQ-011 The block SHALL have port rsp_id, output, 1 (originating requester), and rsp_err, output, 1 (timeout abort).
REQ-012 The block SHALL have port rsp_ready, input, 1: the result is consumed when high together with rsp_valid.

Function
REQ-013 The block SHALL implement the states IDLE, SETUP, RUN and RESP.
REQ-014 In IDLE the block SHALL raise req0_ready or req1_ready, never both, for the arbitration winner, and only while that requester's valid is high.
REQ-015 Arbitration SHALL be round-robin: a single 1-bit pointer names the preferred requester; if only one requester is valid, it wins.
REQ-016 On an accepted transfer the pointer SHALL move to the other requester; the block SHALL latch the data and id and go IDLE->SETUP.
REQ-017 In SETUP, core_start SHALL be 0 and core_data_in SHALL hold the latched word; the block SHALL go to RUN after 1 cycle.
REQ-018 In RUN, core_start SHALL be held at 1 and core_data_in SHALL be held stable.
REQ-019 In RUN, the block SHALL count cycles in a counter that is cleared on entry to RUN.
REQ-020 When core_done is sampled at 1 in RUN, the block SHALL capture core_data_out into rsp_data, set rsp_err=0 and go to RESP.
REQ-021 If the RUN counter reaches TIMEOUT without core_done, the block SHALL go to RESP with rsp_err=1 and rsp_data=0.
REQ-022 core_start SHALL be 0 in every state other than RUN, which guarantees at least 1 low cycle between jobs.
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_data, rsp_id and rsp_err SHALL be stable until rsp_ready is sampled high; the block then goes to IDLE.
REQ-024 The block SHALL ignore core_done in IDLE, SETUP and RESP; this means no capture and no state change.
REQ-025 The block SHALL return to IDLE no earlier than the cycle after the rsp handshake, so at most one job is in flight.
REQ-026 The minimum latency, from accept to rsp_valid, SHALL be 1 SETUP cycle, plus the core's run cycles, plus 1.

Reset
REQ-027 While rst_n=0 the block SHALL hold state=IDLE, pointer=0, counter=0, core_start=0, core_data_in=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, and req0_ready=req1_ready=0.
REQ-028 Reset asserted mid-RUN or mid-RESP SHALL drop the job with no response, and core_start SHALL fall immediately.
REQ-029 The first grant after reset with both requesters valid SHALL go to requester 0.

Verification
REQ-030 Single job: req0 offers 12'd2959; the core model returns 12'd1234 after 20 cycles -> core_start high throughout RUN, then rsp_valid with rsp_data=1234, rsp_id=0, rsp_err=0.
REQ-031 Contention: both requesters valid continuously with words 12'd59 and 12'd2959 -> grants alternate 0,1,0,1 and rsp_id follows the same order.
REQ-032 Back-pressure: rsp_ready is held 0 for 10 cycles -> rsp_valid and rsp_data stay stable, no new accept, core_start=0.
REQ-033 Timeout: with TIMEOUT=8, the core never asserts done -> rsp_err=1 and rsp_data=0 exactly 8 RUN cycles after core_start rises.
REQ-034 Reset mid-RUN: rst_n is pulsed low -> all outputs equal their reset values asynchronously, no rsp is issued, and the next grant goes to requester 0.
REQ-035 A spurious core_done pulse in IDLE -> no state change and no rsp_valid.
